shift_ex_stage: RTL and testbench

SHIFT_EX_STAGE -- requirements
Module: shift_ex_stage

---
 rtl/shift_ex_stage.sv | 159 +++++++++++++++
 tb/tb_shift_ex_stage.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_ex_stage.sv
// shift_ex_stage: two-stage 16-bit shift execute unit (SLL/SRA/ROR) with valid/ready flow.
// Build option SHIFT_ROR_EN adds the rotate path; without it mode 10 is reported illegal.
module shift_ex_stage #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [3:0]       in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic             out_z,
    output logic [TAG_W-1:0] out_rd,
    output logic             out_illegal
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
`ifdef SHIFT_ROR_EN
    localparam logic [1:0] MODE_ROR = 2'b10;
`endif

    // Illegal modes fall into the default arm and pass the operand through.
    function automatic logic [15:0] shift_by(
        input logic [15:0] v,
        input logic [1:0]  mode,
        input logic [3:0]  amt
    );
        logic [15:0] r;
        r = v;
        case (mode)
            MODE_SLL: r = v << amt;
            MODE_SRA: r = $unsigned($signed(v) >>> amt);
`ifdef SHIFT_ROR_EN
            MODE_ROR: r = (v >> amt) | (v << (5'd16 - {1'b0, amt}));
`endif
            default:  r = v;
        endcase
        return r;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [15:0]      s1_val_q, s1_val_d;
    logic [1:0]       s1_shamt_q, s1_shamt_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic             s1_illegal_q, s1_illegal_d;
    logic [TAG_W-1:0] s1_rd_q, s1_rd_d;

    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_result_q, out_result_d;
    logic             out_z_q, out_z_d;
    logic [TAG_W-1:0] out_rd_q, out_rd_d;
    logic             out_illegal_q, out_illegal_d;

    logic             s2_advance;
    logic             s1_advance;
    logic             accept;
    logic             s2_load;
    logic             in_illegal;
    logic [15:0]      s1_result;
    logic [15:0]      s2_result;

`ifdef SHIFT_ROR_EN
    assign in_illegal = (in_mode == 2'b11);
`else
    assign in_illegal = in_mode[1];
`endif

    assign s2_advance = !out_valid_q || out_ready;
    assign s1_advance = !s1_valid_q || s2_advance;
    // Upstream never stalls on a flush; the bundle is simply dropped.
    assign in_ready   = s1_advance || flush;
    assign accept     = in_valid && s1_advance && !flush;
    assign s2_load    = s1_valid_q && s2_advance && !flush;

    assign s1_result  = shift_by(in_a, in_mode, {in_shamt[3:2], 2'b00});
    assign s2_result  = shift_by(s1_val_q, s1_mode_q, {2'b00, s1_shamt_q});

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_val_d     = s1_val_q;
        s1_shamt_d   = s1_shamt_q;
        s1_mode_d    = s1_mode_q;
        s1_illegal_d = s1_illegal_q;
        s1_rd_d      = s1_rd_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_advance) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_val_d     = s1_result;
            s1_shamt_d   = in_shamt[1:0];
            s1_mode_d    = in_mode;
            s1_illegal_d = in_illegal;
            s1_rd_d      = in_rd;
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_z_d       = out_z_q;
        out_rd_d      = out_rd_q;
        out_illegal_d = out_illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (s2_advance) begin
            out_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            out_result_d  = s2_result;
            out_z_d       = (s2_result == 16'h0000);
            out_rd_d      = s1_rd_q;
            out_illegal_d = s1_illegal_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_val_q      <= 16'h0000;
            s1_shamt_q    <= 2'b00;
            s1_mode_q     <= 2'b00;
            s1_illegal_q  <= 1'b0;
            s1_rd_q       <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= 16'h0000;
            out_z_q       <= 1'b0;
            out_rd_q      <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_val_q      <= s1_val_d;
            s1_shamt_q    <= s1_shamt_d;
            s1_mode_q     <= s1_mode_d;
            s1_illegal_q  <= s1_illegal_d;
            s1_rd_q       <= s1_rd_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_z_q       <= out_z_d;
            out_rd_q      <= out_rd_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_z       = out_z_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Testbench for shift_ex_stage: scenario tasks with a scoreboard queue of expected results.
// Honours SHIFT_ROR_EN the same way as the design.
module tb_shift_ex_stage;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_a = 16'h0000;
    logic [3:0]       in_shamt = 4'h0;
    logic [1:0]       in_mode = 2'b00;
    logic [TAG_W-1:0] in_rd = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_result;
    logic             out_z;
    logic [TAG_W-1:0] out_rd;
    logic             out_illegal;

    shift_ex_stage #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_shamt(in_shamt), .in_mode(in_mode), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_z(out_z),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic [3:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [3:0]  sh;
        logic [1:0]  m;
        logic [15:0] r;
        logic        z;
        logic        ill;
    } vec_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic acc, cons, rdy, have_want, got_v;
    exp_t got, want;

    function automatic exp_t model(input logic [15:0] a, input logic [3:0] sh,
                                   input logic [1:0] m, input logic [3:0] rd);
        exp_t e;
        logic [15:0] r;
        r = a;
        e.ill = 1'b0;
        case (m)
            2'b00: for (int i = 0; i < int'(sh); i++) r = {r[14:0], 1'b0};
            2'b01: for (int i = 0; i < int'(sh); i++) r = {r[15], r[15:1]};
`ifdef SHIFT_ROR_EN
            2'b10: for (int i = 0; i < int'(sh); i++) r = {r[0], r[15:1]};
`endif
            default: e.ill = 1'b1;
        endcase
        e.res = r;
        e.z = (r == 16'h0000);
        e.rd = rd;
        return e;
    endfunction

    // One clock: drive, sample just before the edge, update scoreboard, return at edge+1.
    task automatic step(input logic v, input logic [15:0] a, input logic [3:0] sh,
                        input logic [1:0] m, input logic [3:0] rd,
                        input logic ordy, input logic fl, input exp_t e);
        in_valid = v; in_a = a; in_shamt = sh; in_mode = m; in_rd = rd;
        out_ready = ordy; flush = fl;
        #1;
        rdy = in_ready;
        acc = v && in_ready && !fl;
        cons = out_valid && ordy && !fl;
        got_v = out_valid;
        got.res = out_result; got.z = out_z; got.rd = out_rd; got.ill = out_illegal;
        have_want = 1'b0;
        want = '0;
        if (cons && sbq.size() > 0) begin
            want = sbq.pop_front();
            have_want = 1'b1;
        end
        if (fl) sbq.delete();
        else if (acc) sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_z !== 1'b0 ||
            out_rd !== 4'h0 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: got v=%b r=%h z=%b rd=%h ill=%b want all zero",
                     out_valid, out_result, out_z, out_rd, out_illegal);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_valid: got %b want 0", out_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_latency();
        exp_t e;
        e = '{res: 16'h0010, z: 1'b0, rd: 4'h5, ill: 1'b0};
        step(1'b1, 16'h0001, 4'd4, 2'b00, 4'h5, 1'b1, 1'b0, e);
        checks++;
        if (acc !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_first_edge: got acc=%b v=%b want acc=1 v=0", acc, out_valid);
        end
        step(1'b0, 16'h0, 4'd0, 2'b00, 4'h0, 1'b1, 1'b0, '0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL lat_second_edge: got v=%b want 1", out_valid);
        end
        step(1'b0, 16'h0, 4'd0, 2'b00, 4'h0, 1'b1, 1'b0, '0);
        checks++;
        if (!cons || !have_want || got !== want) begin
            errors++;
            $display("FAIL lat_sll_result: got cons=%b %h want %h", cons, got, e);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_drained: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_patterns();
        vec_t tab[$];
        int   idx = 0;
        int   outs = 0;
        exp_t e;
        tab.push_back({16'h8000, 4'd15, 2'b01, 16'hFFFF, 1'b0, 1'b0});
        tab.push_back({16'h4000, 4'd14, 2'b01, 16'h0001, 1'b0, 1'b0});
        tab.push_back({16'h8000, 4'd1,  2'b00, 16'h0000, 1'b1, 1'b0});
`ifdef SHIFT_ROR_EN
        tab.push_back({16'h0001, 4'd1,  2'b10, 16'h8000, 1'b0, 1'b0});
        tab.push_back({16'hA5C3, 4'd0,  2'b10, 16'hA5C3, 1'b0, 1'b0});
        tab.push_back({16'h1234, 4'd8,  2'b10, 16'h3412, 1'b0, 1'b0});
        tab.push_back({16'h8001, 4'd4,  2'b10, 16'h1800, 1'b0, 1'b0});
        tab.push_back({16'h00FF, 4'd15, 2'b10, 16'h01FE, 1'b0, 1'b0});
`else
        tab.push_back({16'h0001, 4'd1,  2'b10, 16'h0001, 1'b0, 1'b1});
        tab.push_back({16'hA5C3, 4'd0,  2'b10, 16'hA5C3, 1'b0, 1'b1});
        tab.push_back({16'h1234, 4'd8,  2'b10, 16'h1234, 1'b0, 1'b1});
        tab.push_back({16'h8001, 4'd4,  2'b10, 16'h8001, 1'b0, 1'b1});
        tab.push_back({16'h00FF, 4'd15, 2'b10, 16'h00FF, 1'b0, 1'b1});
`endif
        tab.push_back({16'h1234, 4'd5,  2'b11, 16'h1234, 1'b0, 1'b1});
        tab.push_back({16'hA5C3, 4'd0,  2'b00, 16'hA5C3, 1'b0, 1'b0});
        tab.push_back({16'hA5C3, 4'd0,  2'b01, 16'hA5C3, 1'b0, 1'b0});
        tab.push_back({16'hFFFF, 4'd15, 2'b00, 16'h8000, 1'b0, 1'b0});
        tab.push_back({16'h7FFF, 4'd15, 2'b01, 16'h0000, 1'b1, 1'b0});
        tab.push_back({16'h0000, 4'd7,  2'b11, 16'h0000, 1'b1, 1'b1});
        tab.push_back({16'h8001, 4'd3,  2'b01, 16'hF000, 1'b0, 1'b0});
        tab.push_back({16'h00F0, 4'd6,  2'b00, 16'h3C00, 1'b0, 1'b0});
        tab.push_back({16'h0F0F, 4'd5,  2'b01, 16'h0078, 1'b0, 1'b0});
        tab.push_back({16'h5555, 4'd0,  2'b11, 16'h5555, 1'b0, 1'b1});
        for (int cyc = 0; cyc < 60 && outs < tab.size(); cyc++) begin
            if (idx < tab.size()) begin
                e = '{res: tab[idx].r, z: tab[idx].z, rd: 4'(idx), ill: tab[idx].ill};
                step(1'b1, tab[idx].a, tab[idx].sh, tab[idx].m, 4'(idx), 1'b1, 1'b0, e);
                checks++;
                if (acc !== 1'b1) begin
                    errors++;
                    $display("FAIL pat_throughput_%0d: got acc=%b want 1", idx, acc);
                end
                if (acc) idx++;
            end else begin
                step(1'b0, 16'h0, 4'd0, 2'b00, 4'h0, 1'b1, 1'b0, '0);
            end
            if (cons) begin
                checks++;
                if (!have_want || got !== want) begin
                    errors++;
                    $display("FAIL pat_result_%0d: got %h want %h", outs, got, want);
                end
                outs++;
            end
        end
        checks++;
        if (outs != tab.size()) begin
            errors++;
            $display("FAIL pat_count: got %0d want %0d", outs, tab.size());
        end
    endtask

    task automatic test_back_to_back();
        int   tag = 1;
        int   outs = 0;
        logic ordy;
        logic exp_acc;
        int   seen[$];
        for (int cyc = 0; cyc < 20 && outs < 3; cyc++) begin
            ordy = (cyc >= 4);
            if (tag <= 3) begin
                exp_acc = (cyc < 2) || (cyc >= 4);
                step(1'b1, 16'h0003, 4'(tag), 2'b00, 4'(tag), ordy, 1'b0,
                     model(16'h0003, 4'(tag), 2'b00, 4'(tag)));
                checks++;
                if (acc !== exp_acc) begin
                    errors++;
                    $display("FAIL b2b_accept_c%0d: got %b want %b", cyc, acc, exp_acc);
                end
                if (acc) tag++;
            end else begin
                step(1'b0, 16'h0, 4'd0, 2'b00, 4'h0, ordy, 1'b0, '0);
            end
            if (cyc >= 2 && cyc < 4) begin
                checks++;
                if (got_v !== 1'b1 || got.rd !== 4'h1 || got.res !== 16'h0006) begin
                    errors++;
                    $display("FAIL b2b_hold_c%0d: got v=%b %h want tag1 0006", cyc, got_v, got);
                end
            end
            if (cons) begin
                checks++;
                if (!have_want || got !== want) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got %h want %h", outs, got, want);
                end
                seen.push_back(int'(got.rd));
                outs++;
            end
        end
        checks++;
        if (seen.size() != 3 || seen[0] != 1 || seen[1] != 2 || seen[2] != 3) begin
            errors++;
            $display("FAIL b2b_order: got %0d results %p want 1,2,3", seen.size(), seen);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        step(1'b1, 16'h0101, 4'd2, 2'b00, 4'h7, 1'b1, 1'b0, model(16'h0101, 4'd2, 2'b00, 4'h7));
        step(1'b1, 16'h0202, 4'd3, 2'b00, 4'h8, 1'b1, 1'b0, model(16'h0202, 4'd3, 2'b00, 4'h8));
        step(1'b1, 16'h0303, 4'd1, 2'b00, 4'h9, 1'b1, 1'b1, '0);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_ready: got %b want 1", rdy);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 4'd0, 2'b00, 4'h0, 1'b1, 1'b0, '0);
            checks++;
            if (got_v !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_quiet_%0d: got v=%b/%b want 0", i, got_v, out_valid);
            end
        end
        e = '{res: 16'hFFF0, z: 1'b0, rd: 4'hA, ill: 1'b0};
        step(1'b1, 16'hFF00, 4'd4, 2'b01, 4'hA, 1'b1, 1'b0, e);
        checks++;
        if (acc !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_next_early: got acc=%b v=%b want 1/0", acc, out_valid);
        end
        step(1'b0, 16'h0, 4'd0, 2'b00, 4'h0, 1'b1, 1'b0, '0);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 16'hFFF0 || out_rd !== 4'hA) begin
            errors++;
            $display("FAIL flush_next_out: got v=%b r=%h rd=%h want 1 fff0 a",
                     out_valid, out_result, out_rd);
        end
        step(1'b0, 16'h0, 4'd0, 2'b00, 4'h0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 16'hBEEF, 4'd3, 2'b11, 4'h3, 1'b0, 1'b0, model(16'hBEEF, 4'd3, 2'b11, 4'h3));
        step(1'b1, 16'h00FF, 4'd1, 2'b00, 4'h4, 1'b0, 1'b0, model(16'h00FF, 4'd1, 2'b00, 4'h4));
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_z !== 1'b0 ||
            out_rd !== 4'h0 || out_illegal !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_outs: got v=%b r=%h z=%b rd=%h ill=%b rdy=%b want zeros rdy=1",
                     out_valid, out_result, out_z, out_rd, out_illegal, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0, 4'd0, 2'b00, 4'h0, 1'b1, 1'b0, '0);
            checks++;
            if (got_v !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale_%0d: got v=%b/%b want 0", i, got_v, out_valid);
            end
        end
        step(1'b1, 16'h8000, 4'd4, 2'b01, 4'h6, 1'b1, 1'b0,
             '{res: 16'hF800, z: 1'b0, rd: 4'h6, ill: 1'b0});
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_fresh_early: got v=%b want 0", out_valid);
        end
        step(1'b0, 16'h0, 4'd0, 2'b00, 4'h0, 1'b1, 1'b0, '0);
        step(1'b0, 16'h0, 4'd0, 2'b00, 4'h0, 1'b1, 1'b0, '0);
        checks++;
        if (!cons || !have_want || got !== want) begin
            errors++;
            $display("FAIL rst_fresh_result: got cons=%b %h want %h", cons, got, want);
        end
    endtask

    task automatic test_random();
        logic        v, ordy, fl, prev_stall, exp_rdy;
        logic [15:0] a;
        logic [3:0]  sh, rd;
        logic [1:0]  m;
        exp_t        prev_got;
        prev_stall = 1'b0;
        prev_got = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 49) == 0);
            a    = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a[15] = 1'b1;
            sh   = 4'($urandom);
            m    = 2'($urandom);
            rd   = 4'($urandom);
            exp_rdy = fl || !(sbq.size() == 2 && !ordy);
            step(v, a, sh, m, rd, ordy, fl, model(a, sh, m, rd));
            checks++;
            if (rdy !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_in_ready_c%0d: got %b want %b", cyc, rdy, exp_rdy);
            end
            if (prev_stall) begin
                checks++;
                if (got_v !== 1'b1 || got !== prev_got) begin
                    errors++;
                    $display("FAIL rnd_hold_c%0d: got v=%b %h want 1 %h", cyc, got_v, got, prev_got);
                end
            end
            if (cons) begin
                checks++;
                if (!have_want || got !== want) begin
                    errors++;
                    $display("FAIL rnd_result_c%0d: got %h want %h", cyc, got, want);
                end
            end
            prev_stall = got_v && !ordy && !fl;
            prev_got = got;
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'h0, 4'd0, 2'b00, 4'h0, 1'b1, 1'b0, '0);
            if (cons) begin
                checks++;
                if (!have_want || got !== want) begin
                    errors++;
                    $display("FAIL rnd_drain_%0d: got %h want %h", i, got, want);
                end
            end
        end
        checks++;
        if (sbq.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rnd_leftover: got %0d pending v=%b want 0", sbq.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_patterns();
        test_back_to_back();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
